// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and execute-unit FSM states.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package alu_pkg;

    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'd4;
    localparam logic [ALU_OP_W-1:0] ALU_MUL  = 3'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRAI = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit consumed per step.
// Latency: WIDTH steps after load; product shows acc including the current step.
// Backpressure: none; the owner decides when to load and step.
module alu_mul_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;

    // Accumulator value after the current step; on the last step this is the
    // final product, so the owner can register it in the same edge.
    assign product = mplier[0] ? (acc + mcand) : acc;
    assign last    = (cnt == SHW'(WIDTH - 1));

    // Operand capture on load, one shift-add iteration per step.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// EX-stage execute unit: single-cycle logic/shift/add/sub, iterative multiply.
// Latency: 1 cycle for single-cycle ops, WIDTH cycles after accept for multiply.
// Backpressure: busy_o high during multiply; start_i is ignored while busy_o=1.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [WIDTH-1:0]    result_o,
    output logic                zero_o
);

    alu_state_t       state;
    alu_state_t       state_nxt;
    logic             mul_load;
    logic             mul_step;
    logic             mul_last;
    logic [WIDTH-1:0] mul_product;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             res_we;
    logic [WIDTH-1:0] res_nxt;
    logic             done_nxt;

    assign shamt = b_i[SHW-1:0];

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (mul_load),
        .step    (mul_step),
        .a       (a_i),
        .b       (b_i),
        .last    (mul_last),
        .product (mul_product)
    );

    // Single-cycle datapath; multiply and the reserved code both yield zero here.
    always_comb begin
        alu_res = '0;
        case (op_i)
            ALU_AND:  alu_res = a_i & b_i;
            ALU_XOR:  alu_res = a_i ^ b_i;
            ALU_SLL:  alu_res = a_i << shamt;
            ALU_ADD:  alu_res = a_i + b_i;
            ALU_SUB:  alu_res = a_i - b_i;
            ALU_SRAI: alu_res = $unsigned($signed(a_i) >>> shamt);
            default:  alu_res = '0;
        endcase
    end

    // Next-state and result-update control for the IDLE/MUL sequencer.
    always_comb begin
        state_nxt = state;
        mul_load  = 1'b0;
        mul_step  = 1'b0;
        res_we    = 1'b0;
        res_nxt   = alu_res;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (op_i == ALU_MUL) begin
                        mul_load  = 1'b1;
                        state_nxt = MUL;
                    end else begin
                        res_we   = 1'b1;
                        done_nxt = 1'b1;
                    end
                end
            end
            MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    res_we    = 1'b1;
                    res_nxt   = mul_product;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any multiply in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output registers: result and zero flag update together with the done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o <= '0;
            zero_o   <= 1'b1;
            done_o   <= 1'b0;
        end else begin
            done_o <= done_nxt;
            if (res_we) begin
                result_o <= res_nxt;
                zero_o   <= (res_nxt == '0);
            end
        end
    end

    assign busy_o = (state == MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, randomized ops
// against an arithmetic reference, and hand-built multi-cycle corner sequences.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result),
        .zero_o   (zero)
    );

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on the operation definitions.
    function automatic logic [W-1:0] ref_alu(input logic [2:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        int          sh;
        logic [63:0] p;
        sh = int'(y % W);
        p  = {32'b0, x} * {32'b0, y};
        case (o)
            3'd0:    return x & y;
            3'd1:    return x ^ y;
            3'd2:    return x << sh;
            3'd3:    return x + y;
            3'd4:    return x - y;
            3'd5:    return p[W-1:0];
            3'd6:    return $unsigned($signed(x) >>> sh);
            default: return '0;
        endcase
    endfunction

    // Issue one request from IDLE and check result, flags and timing.
    task automatic run_req(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] expv);
        int n;
        int bcnt;
        int exp_lat;
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        n = 0; bcnt = 0;
        while (!done && n < 100) begin
            if (busy) bcnt++;
            tick();
            n++;
        end
        exp_lat = (o == 3'd5) ? W : 0;
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(bcnt), 64'(exp_lat));
        check({tag, " busy at done"}, 64'(busy), 64'(0));
        check({tag, " result"}, 64'(result), 64'(expv));
        check({tag, " zero"}, 64'(zero), 64'(expv == '0));
        tick();
        check({tag, " done single pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        int n;
        int dcnt;
        logic [2:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{"add wrap",   3'd3, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        vecs[1] = '{"sub neg",    3'd4, 32'd5,         32'd7,         32'hFFFF_FFFE};
        vecs[2] = '{"and",        3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[3] = '{"xor equal",  3'd1, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h0000_0000};
        vecs[4] = '{"sll masked", 3'd2, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
        vecs[5] = '{"srai",       3'd6, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        vecs[6] = '{"mul all1",   3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[7] = '{"mul dec",    3'd5, 32'd12345,     32'd6789,      32'd83810205};
        vecs[8] = '{"op7",        3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000};

        rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset then idle.
        for (int i = 0; i < 5; i++) begin
            check("idle after reset {result,zero,busy,done}",
                  64'({result, zero, busy, done}), 64'({32'h0, 1'b1, 1'b0, 1'b0}));
            tick();
        end

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            run_req(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);
        end

        // Randomized requests against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : $urandom;
            run_req($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, ref_alu(ro, ra, rb));
        end

        // Start pulsed during a multiply is ignored; reissue in the done cycle.
        start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd1000;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            if (n == 5) begin
                start = 1'b1; op = 3'd3; a = 32'd1; b = 32'd2;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check("mul with ignored start latency", 64'(n), 64'(W));
        check("mul with ignored start result", 64'(result), 64'(1000000));
        start = 1'b1; op = 3'd3; a = 32'd10; b = 32'd20;
        tick();
        start = 1'b0;
        check("back-to-back add done", 64'(done), 64'(1));
        check("back-to-back add result", 64'(result), 64'(30));
        check("back-to-back add busy", 64'(busy), 64'(0));
        tick();
        check("back-to-back add done drop", 64'(done), 64'(0));

        // Reset in the middle of a multiply aborts it.
        start = 1'b1; op = 3'd5; a = 32'd7; b = 32'd9;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("busy before abort", 64'(busy), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort {result,zero,busy,done}",
              64'({result, zero, busy, done}), 64'({32'h0, 1'b1, 1'b0, 1'b0}));
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) dcnt++;
            tick();
        end
        check("no done or busy after abort", 64'(dcnt), 64'(0));
        run_req("mul 3x4 after abort", 3'd5, 32'd3, 32'd4, 32'd12);

        // Reset and start in the same cycle: reset wins.
        rst = 1'b1; start = 1'b1; op = 3'd3; a = 32'd5; b = 32'd5;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst+start {result,done,busy}", 64'({result, done, busy}), 64'({32'h0, 1'b0, 1'b0}));
        tick();
        check("rst+start later done", 64'({result, done, busy}), 64'({32'h0, 1'b0, 1'b0}));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
